// File: rtl/qspi_xio_pkg.sv
// ============================================================================
// Module      : qspi_xio_pkg
// Description : Shared types and helpers for the QSPI data-wire SERDES.
//               Includes mode encodings, FSM states, pin counts per mode
//               and the shift-cycle count helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qspi_xio_pkg;

  typedef enum logic [1:0] {
    MODE_SPI  = 2'd0,
    MODE_DUAL = 2'd1,
    MODE_QUAD = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PINS_SPI  = 1;
  localparam int PINS_DUAL = 2;
  localparam int PINS_QUAD = 4;

  // Number of data pins that toggle in a given mode
  function automatic int pins_per_mode(input mode_t m);
    case (m)
      MODE_QUAD: return PINS_QUAD;
      MODE_DUAL: return PINS_DUAL;
      default:   return PINS_SPI;
    endcase
  endfunction

  // Output-enable pattern for the pins a mode drives
  function automatic logic [3:0] pin_mask(input mode_t m);
    return 4'((1 << pins_per_mode(m)) - 1);
  endfunction

  // SHIFT cycles minus one for (len+1) bytes: quad 1, dual 2, single 4 per byte
  function automatic logic [3:0] shift_cycles_m1(input mode_t m, input logic [1:0] len);
    case (m)
      MODE_QUAD: return {2'b00, len};
      MODE_DUAL: return {1'b0, len, 1'b1};
      default:   return {len, 2'b11};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_xio_capture.sv
// ============================================================================
// Module      : qspi_xio_capture
// Description : Read-side capture for the QSPI SERDES. A READ_LATENCY-deep
//               tag line marks which returning pin pairs belong to a shift
//               cycle, and tagged pairs shift into a right-justified
//               accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_xio_capture
  import qspi_xio_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        tag_in,
  input  mode_t       mode,
  input  logic [7:0]  pin_v,
  output logic [31:0] data
);

  logic [READ_LATENCY-1:0] tags;
  logic                    tag_out;
  logic [31:0]             data_nxt;

  generate
    if (READ_LATENCY == 1) begin : g_lat_one
      // Single-stage tag delay
      always_ff @(posedge clk or posedge rst) begin
        if (rst) tags <= '0;
        else     tags <= tag_in;
      end
    end else begin : g_lat_multi
      // Multi-stage tag delay matching the I/O cell round trip
      always_ff @(posedge clk or posedge rst) begin
        if (rst) tags <= '0;
        else     tags <= {tags[READ_LATENCY-2:0], tag_in};
      end
    end
  endgenerate

  assign tag_out = tags[READ_LATENCY-1];

  // Unpack the returning pair (earlier bit in the odd position) into the accumulator
  always_comb begin
    data_nxt = data;
    case (mode)
      MODE_QUAD: data_nxt = {data[23:0], pin_v[7], pin_v[5], pin_v[3], pin_v[1],
                                         pin_v[6], pin_v[4], pin_v[2], pin_v[0]};
      MODE_DUAL: data_nxt = {data[27:0], pin_v[3], pin_v[1], pin_v[2], pin_v[0]};
      default:   data_nxt = {data[29:0], pin_v[3:2]};
    endcase
  end

  // Accumulator: cleared when a capturing transfer is accepted, then held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          data <= 32'h0;
    else if (clear)   data <= 32'h0;
    else if (tag_out) data <= data_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/qspi_xio_serdes.sv
// ============================================================================
// Module      : qspi_xio_serdes
// Description : Serializer/deserializer between the QSPI flash controller
//               and four DDR pin cells. Handles 1-4 byte transfers in single,
//               dual (optional) or quad mode and compensates the I/O cell
//               read latency.
//               Optional feature macro: QSPI_DUAL_EN (mode 1 = dual I/O;
//               without it mode 1 behaves as single SPI).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_xio_serdes
  import qspi_xio_pkg::*;
#(
  parameter int READ_LATENCY = 2  // legal range 1..4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic        i_wr,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_len,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_sck_en,
  output logic [3:0]  o_oe,
  output logic [7:0]  o_pin_v,
  input  logic [7:0]  i_pin_v
);

  localparam logic [3:0] DRAIN_LOAD = 4'(READ_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  mode_t       mode_in;
  mode_t       mode_q;
  logic        wr_q;
  logic [3:0]  cnt;
  logic [31:0] sr;
  logic        accept;
  logic        cap_in;
  logic        cap_q;
  logic [7:0]  pin_raw;

  // Normalise the requested mode: 3 aliases quad, dual only when built in
  always_comb begin
    case (i_mode)
      2'd0:    mode_in = MODE_SPI;
`ifdef QSPI_DUAL_EN
      2'd1:    mode_in = MODE_DUAL;
`else
      2'd1:    mode_in = MODE_SPI;
`endif
      default: mode_in = MODE_QUAD;
    endcase
  end

  // Requests are only taken in IDLE, so a strobe during DONE is dropped
  assign accept = (state == ST_IDLE) && i_stb;
  // Reads capture; single mode is full duplex so its writes capture too
  assign cap_in = !i_wr || (mode_in == MODE_SPI);
  assign cap_q  = !wr_q || (mode_q == MODE_SPI);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)      state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == 4'd0) state_nxt = cap_q ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (cnt == 4'd0) state_nxt = ST_DONE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, shift/drain counter and output shift register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q <= MODE_SPI;
      wr_q   <= 1'b0;
      cnt    <= 4'd0;
      sr     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q <= mode_in;
            wr_q   <= i_wr;
            sr     <= i_data;
            cnt    <= shift_cycles_m1(mode_in, i_len);
          end
        end
        ST_SHIFT: begin
          case (mode_q)
            MODE_QUAD: sr <= {sr[23:0], 8'h00};
            MODE_DUAL: sr <= {sr[27:0], 4'h0};
            default:   sr <= {sr[29:0], 2'b00};
          endcase
          // Reload with the drain length on the last shift cycle
          cnt <= (cnt == 4'd0) ? DRAIN_LOAD : cnt - 4'd1;
        end
        ST_DRAIN: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state == ST_SHIFT) || (state == ST_DRAIN);
  assign o_valid  = (state == ST_DONE);
  assign o_sck_en = (state == ST_SHIFT);

  // Output enables: only during SHIFT, pin0 always driven in single mode
  always_comb begin
    o_oe = 4'b0000;
    if (state == ST_SHIFT) begin
      if (mode_q == MODE_SPI) o_oe = 4'b0001;
      else if (wr_q)          o_oe = pin_mask(mode_q);
    end
  end

  // Map the top of the shift register onto pin pairs, earlier bit in [2k+1]
  always_comb begin
    pin_raw = 8'h00;
    case (mode_q)
      MODE_QUAD: begin
        for (int k = 0; k < 4; k++) begin
          pin_raw[2*k+1] = sr[28+k];
          pin_raw[2*k]   = sr[24+k];
        end
      end
      MODE_DUAL: begin
        pin_raw[3] = sr[31];
        pin_raw[1] = sr[30];
        pin_raw[2] = sr[29];
        pin_raw[0] = sr[28];
      end
      default: pin_raw[1:0] = sr[31:30];
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_pin_mask
      assign o_pin_v[2*k+1:2*k] = pin_raw[2*k+1:2*k] & {2{o_oe[k]}};
    end
  endgenerate

  qspi_xio_capture #(
    .READ_LATENCY (READ_LATENCY)
  ) u_capture (
    .clk    (i_clk),
    .rst    (i_reset),
    .clear  (accept && cap_in),
    .tag_in ((state == ST_SHIFT) && cap_q),
    .mode   (mode_q),
    .pin_v  (i_pin_v),
    .data   (o_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_qspi_xio_serdes.sv
// ============================================================================
// Module      : tb_qspi_xio_serdes
// Description : Self-checking bench for qspi_xio_serdes. A flash/IO-cell model
//               returns data with READ_LATENCY delay; expected pin traffic and
//               completion results are queued at stimulus time and checked
//               when the DUT produces them. Honours QSPI_DUAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_xio_serdes;

  localparam int LAT      = 2;
  localparam int CLK_HALF = 5;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  len = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic        busy;
  logic        valid;
  logic [31:0] rdata;
  logic        sck_en;
  logic [3:0]  oe;
  logic [7:0]  pin_out;
  logic [7:0]  pin_in;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [11:0] pin_q[$];
  logic [31:0] fl_word = 32'h0;
  int          fl_w = 8;
  int          fl_eff = 2;
  int          fl_pos = 0;
  logic [7:0]  pipe [0:3];
  logic [31:0] last_rdata = 32'h0;
  int          rise_cyc = 0;
  logic        prev_busy = 1'b0;

  always #CLK_HALF clk = ~clk;

  qspi_xio_serdes #(
    .READ_LATENCY (LAT)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_stb    (stb),
    .i_wr     (wr),
    .i_mode   (mode),
    .i_len    (len),
    .i_data   (wdata),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_data   (rdata),
    .o_sck_en (sck_en),
    .o_oe     (oe),
    .o_pin_v  (pin_out),
    .i_pin_v  (pin_in)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Effective mode: 0 single, 1 dual, 2 quad
  function automatic int eff_mode(input logic [1:0] m);
    if (m == 2'd0) return 0;
`ifdef QSPI_DUAL_EN
    if (m == 2'd1) return 1;
`else
    if (m == 2'd1) return 0;
`endif
    return 2;
  endfunction

  // Bits idx*w .. of a word, MSB first, right-justified
  function automatic logic [7:0] chunk(input logic [31:0] word, input int idx, input int w);
    logic [31:0] t;
    t = word << (idx * w);
    return 8'(t >> (32 - w));
  endfunction

  // Pin packing: pin k pair in {[2k+1],[2k]}, earlier bit in [2k+1]
  function automatic logic [7:0] pack_pair(input int eff, input logic [7:0] b);
    logic [7:0] v;
    v = 8'h00;
    if (eff == 2) begin
      for (int k = 0; k < 4; k++) begin
        v[2*k+1] = b[4+k];
        v[2*k]   = b[k];
      end
    end else if (eff == 1) begin
      v[3] = b[3]; v[1] = b[2]; v[2] = b[1]; v[0] = b[0];
    end else begin
      v[1:0] = b[1:0];
    end
    return v;
  endfunction

  // Flash drive onto the pins; pins it does not own carry junk
  function automatic logic [7:0] flash_pair(input logic [31:0] word, input int pos,
                                            input int eff, input int w);
    logic [7:0] b;
    logic [7:0] v;
    b = chunk(word, pos, w);
    if (eff == 2) return pack_pair(2, b);
    if (eff == 1) begin
      v = pack_pair(1, b);
      return {4'hA, v[3:0]};
    end
    return {4'h5, b[1:0], 2'b10};
  endfunction

  assign pin_in = pipe[LAT-1];

  // Flash + I/O cell model: one pair per sck cycle, returned LAT clocks later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= sck_en ? flash_pair(fl_word, fl_pos, fl_eff, fl_w) : 8'hFF;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    if (sck_en)     fl_pos <= fl_pos + 1;
    else if (!busy) fl_pos <= 0;
  end

  // Monitor: pin traffic per shift cycle and completion results
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [11:0] p;
    if (sck_en) begin
      if (pin_q.size() == 0) check_eq("sck_without_expect", 64'(sck_en), 64'd0);
      else begin
        p = pin_q.pop_front();
        check_eq("pins", 64'({oe, pin_out}), 64'(p));
      end
    end else begin
      check_eq("idle_pins", 64'({oe, pin_out}), 64'd0);
    end
    if (busy && !prev_busy) rise_cyc <= cyc;
    prev_busy <= busy;
    if (valid) begin
      check_eq("busy_in_done", 64'(busy), 64'd0);
      if (exp_q.size() == 0) check_eq("unexpected_valid", 64'(valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("rdata", 64'(rdata), 64'(e.data));
        check_eq("latency", 64'(cyc - rise_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Queue the expected pin traffic and completion of one transfer
  task automatic push_exp(input logic w, input logic [1:0] m, input logic [1:0] l,
                          input logic [31:0] d, input logic [31:0] fw);
    int         eff, bw, ncyc, nbits;
    logic [3:0] oe_e;
    logic [7:0] v;
    logic       cap;
    exp_t       e;
    eff   = eff_mode(m);
    bw    = (eff == 2) ? 8 : ((eff == 1) ? 4 : 2);
    ncyc  = (int'(l) + 1) * 8 / bw;
    nbits = 8 * (int'(l) + 1);
    if (eff == 0)      oe_e = 4'b0001;
    else if (!w)       oe_e = 4'b0000;
    else if (eff == 1) oe_e = 4'b0011;
    else               oe_e = 4'b1111;
    for (int c = 0; c < ncyc; c++) begin
      v = (oe_e != 4'b0000) ? pack_pair(eff, chunk(d, c, bw)) : 8'h00;
      pin_q.push_back({oe_e, v});
    end
    cap = !w || (eff == 0);
    e.data = cap ? (fw >> (32 - nbits)) : last_rdata;
    e.lat  = ncyc + (cap ? LAT : 0) + 1;
    last_rdata = e.data;
    exp_q.push_back(e);
    fl_word = fw;
    fl_w    = bw;
    fl_eff  = eff;
  endtask

  task automatic start_xfer(input logic w, input logic [1:0] m, input logic [1:0] l,
                            input logic [31:0] d, input logic [31:0] fw);
    @(negedge clk);
    push_exp(w, m, l, d, fw);
    stb = 1'b1; wr = w; mode = m; len = l; wdata = d;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pin_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("wait_timeout", 64'(exp_q.size() + pin_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin : main
    int   nv, n, last_v;
    logic pb;

    repeat (3) @(negedge clk);
    check_eq("rst_busy",  64'(busy),    64'd0);
    check_eq("rst_valid", 64'(valid),   64'd0);
    check_eq("rst_data",  64'(rdata),   64'd0);
    check_eq("rst_sck",   64'(sck_en),  64'd0);
    check_eq("rst_oe",    64'(oe),      64'd0);
    check_eq("rst_pins",  64'(pin_out), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    start_xfer(1'b1, 2'd2, 2'd3, 32'hA5C3_0F96, 32'h0);        wait_done(200);
    start_xfer(1'b0, 2'd2, 2'd1, 32'h0,         32'h3C7E_0000); wait_done(200);
    start_xfer(1'b1, 2'd0, 2'd0, 32'hB200_0000, 32'h4D00_0000); wait_done(200);
    start_xfer(1'b0, 2'd0, 2'd1, 32'h1234_0000, 32'h9A6B_0000); wait_done(200);
    start_xfer(1'b0, 2'd3, 2'd3, 32'h0,         32'hDEAD_BEEF); wait_done(200);
    start_xfer(1'b1, 2'd1, 2'd0, 32'hE100_0000, 32'h6900_0000); wait_done(200);
    start_xfer(1'b0, 2'd1, 2'd2, 32'h0,         32'hC35A_8100); wait_done(200);
    start_xfer(1'b1, 2'd2, 2'd0, 32'h7700_0000, 32'h0);        wait_done(200);

    // Random transfers
    for (int i = 0; i < 8; i++) begin
      start_xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom, $urandom);
      wait_done(200);
    end

    // Strobe held high: each accept must land exactly in the cycle after o_valid
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 2'd2, 2'd0, 32'h5A00_0000, 32'h0);
    stb = 1'b1; wr = 1'b1; mode = 2'd2; len = 2'd0; wdata = 32'h5A00_0000;
    nv = 0; n = 0; last_v = -100; pb = 1'b0;
    while (nv < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy && !pb && nv > 0) check_eq("accept_gap", 64'(cyc - last_v), 64'd2);
      pb = busy;
      if (valid) begin
        nv++;
        last_v = cyc;
        if (nv == 3) stb = 1'b0;
      end
    end
    stb = 1'b0;
    check_eq("held_valid_count", 64'(nv), 64'd3);
    wait_done(200);

    // Reset during clock 2 of a quad 4-byte write
    @(negedge clk);
    push_exp(1'b1, 2'd2, 2'd3, 32'hFFFF_FFFF, 32'h0);
    stb = 1'b1; wr = 1'b1; mode = 2'd2; len = 2'd3; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_oe",    64'(oe),      64'd0);
    check_eq("abort_sck",   64'(sck_en),  64'd0);
    check_eq("abort_busy",  64'(busy),    64'd0);
    check_eq("abort_pins",  64'(pin_out), 64'd0);
    check_eq("abort_valid", 64'(valid),   64'd0);
    check_eq("abort_data",  64'(rdata),   64'd0);
    pin_q.delete();
    exp_q.delete();
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("post_abort_busy", 64'(busy), 64'd0);

    // Normal operation after the abort
    start_xfer(1'b0, 2'd2, 2'd3, 32'h0, 32'h0123_4567); wait_done(200);
    start_xfer(1'b1, 2'd2, 2'd3, 32'hA5C3_0F96, 32'h0); wait_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
